snake_motion_ctrl: RTL and testbench



---
 rtl/snake_pkg.sv | 23 ++
 rtl/snake_next_head.sv | 37 +++
 rtl/snake_motion_ctrl.sv | 170 +++++++++++++++++
 tb/tb_snake_motion_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared grid, direction and game-state definitions for the snake motion logic.
package snake_pkg;

    localparam int GRID_W = 3;
    localparam logic [GRID_W-1:0] GRID_MAX = 3'd7;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // Opposite directions differ only in the upper encoding bit.
    function automatic logic [1:0] opposite(input logic [1:0] dir);
        return dir ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculation; flags moves that would leave the 8x8 grid.
module snake_next_head
    import snake_pkg::*;
(
    input  logic [GRID_W-1:0] head_x,
    input  logic [GRID_W-1:0] head_y,
    input  logic [1:0]        dir,
    output logic [GRID_W-1:0] next_x,
    output logic [GRID_W-1:0] next_y,
    output logic              off_grid
);

    always_comb begin
        next_x   = head_x;
        next_y   = head_y;
        off_grid = 1'b0;
        case (dir)
            DIR_RIGHT: begin
                next_x   = head_x + 3'd1;
                off_grid = (head_x == GRID_MAX);
            end
            DIR_DOWN: begin
                next_y   = head_y + 3'd1;
                off_grid = (head_y == GRID_MAX);
            end
            DIR_LEFT: begin
                next_x   = head_x - 3'd1;
                off_grid = (head_x == '0);
            end
            default: begin
                next_y   = head_y - 3'd1;
                off_grid = (head_y == '0);
            end
        endcase
    end

endmodule

// File: rtl/snake_motion_ctrl.sv
// Snake position register, step timer, direction arbitration and IDLE/RUN/OVER
// game FSM feeding the downstream collision detector.
module snake_motion_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int START_X  = 3,
    parameter int START_Y  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dir_valid,
    input  logic [1:0]        dir_in,
    input  logic              self_collision,
    output logic [GRID_W-1:0] head_x,
    output logic [GRID_W-1:0] head_y,
    output logic [GRID_W-1:0] body1_x,
    output logic [GRID_W-1:0] body1_y,
    output logic [GRID_W-1:0] body2_x,
    output logic [GRID_W-1:0] body2_y,
    output logic              edge_hit,
    output logic              running,
    output logic              game_over,
    output logic              step_pulse,
    output logic [7:0]        step_count
);

    localparam logic [GRID_W-1:0] HEAD_X0  = GRID_W'(START_X);
    localparam logic [GRID_W-1:0] BODY1_X0 = GRID_W'(START_X - 1);
    localparam logic [GRID_W-1:0] BODY2_X0 = GRID_W'(START_X - 2);
    localparam logic [GRID_W-1:0] ROW_Y0   = GRID_W'(START_Y);
    localparam logic [7:0]        TICK_LAST = 8'(TICK_DIV - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t            state_q, state_d;
    logic [GRID_W-1:0] head_x_q, head_x_d, head_y_q, head_y_d;
    logic [GRID_W-1:0] body1_x_q, body1_x_d, body1_y_q, body1_y_d;
    logic [GRID_W-1:0] body2_x_q, body2_x_d, body2_y_q, body2_y_d;
    logic [1:0]        cur_dir_q, cur_dir_d, pend_dir_q, pend_dir_d;
    logic [7:0]        tick_q, tick_d, step_count_q, step_count_d;
    logic              edge_hit_q, edge_hit_d, step_pulse_q, step_pulse_d;

    logic [GRID_W-1:0] next_x, next_y;
    logic              off_grid, step_cycle, dir_ok;

    snake_next_head u_next_head (
        .head_x   (head_x_q),
        .head_y   (head_y_q),
        .dir      (pend_dir_q),
        .next_x   (next_x),
        .next_y   (next_y),
        .off_grid (off_grid)
    );

    assign step_cycle = (tick_q == TICK_LAST);
    // Reversal is judged against the direction actually moved, not the pending one.
    assign dir_ok     = dir_valid && (dir_in != opposite(cur_dir_q));

    always_comb begin
        state_d      = state_q;
        head_x_d     = head_x_q;
        head_y_d     = head_y_q;
        body1_x_d    = body1_x_q;
        body1_y_d    = body1_y_q;
        body2_x_d    = body2_x_q;
        body2_y_d    = body2_y_q;
        cur_dir_d    = cur_dir_q;
        pend_dir_d   = pend_dir_q;
        tick_d       = tick_q;
        step_count_d = step_count_q;
        edge_hit_d   = edge_hit_q;
        step_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dir_ok) pend_dir_d = dir_in;
                if (start)  state_d = ST_RUN;
            end
            ST_RUN: begin
                if (dir_ok) pend_dir_d = dir_in;
                tick_d = step_cycle ? 8'd0 : tick_q + 8'd1;
                // Collision ends the game before any shift on the same cycle.
                if (self_collision) begin
                    state_d = ST_OVER;
                end else if (step_cycle) begin
                    if (off_grid) begin
                        state_d    = ST_OVER;
                        edge_hit_d = 1'b1;
                    end else begin
                        body2_x_d    = body1_x_q;
                        body2_y_d    = body1_y_q;
                        body1_x_d    = head_x_q;
                        body1_y_d    = head_y_q;
                        head_x_d     = next_x;
                        head_y_d     = next_y;
                        cur_dir_d    = pend_dir_q;
                        step_count_d = sat_inc(step_count_q);
                        step_pulse_d = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_d      = ST_RUN;
                    head_x_d     = HEAD_X0;
                    head_y_d     = ROW_Y0;
                    body1_x_d    = BODY1_X0;
                    body1_y_d    = ROW_Y0;
                    body2_x_d    = BODY2_X0;
                    body2_y_d    = ROW_Y0;
                    cur_dir_d    = DIR_RIGHT;
                    pend_dir_d   = DIR_RIGHT;
                    tick_d       = 8'd0;
                    step_count_d = 8'd0;
                    edge_hit_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            head_x_q     <= HEAD_X0;
            head_y_q     <= ROW_Y0;
            body1_x_q    <= BODY1_X0;
            body1_y_q    <= ROW_Y0;
            body2_x_q    <= BODY2_X0;
            body2_y_q    <= ROW_Y0;
            cur_dir_q    <= DIR_RIGHT;
            pend_dir_q   <= DIR_RIGHT;
            tick_q       <= 8'd0;
            step_count_q <= 8'd0;
            edge_hit_q   <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_x_q     <= head_x_d;
            head_y_q     <= head_y_d;
            body1_x_q    <= body1_x_d;
            body1_y_q    <= body1_y_d;
            body2_x_q    <= body2_x_d;
            body2_y_q    <= body2_y_d;
            cur_dir_q    <= cur_dir_d;
            pend_dir_q   <= pend_dir_d;
            tick_q       <= tick_d;
            step_count_q <= step_count_d;
            edge_hit_q   <= edge_hit_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign head_x     = head_x_q;
    assign head_y     = head_y_q;
    assign body1_x    = body1_x_q;
    assign body1_y    = body1_y_q;
    assign body2_x    = body2_x_q;
    assign body2_y    = body2_y_q;
    assign edge_hit   = edge_hit_q;
    assign running    = (state_q == ST_RUN);
    assign game_over  = (state_q == ST_OVER);
    assign step_pulse = step_pulse_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_snake_motion_ctrl.sv
// Directed bench for snake_motion_ctrl with TICK_DIV=4 and start cell (3,3).
module tb_snake_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_in = 2'b00;
    logic       self_collision = 1'b0;
    logic [2:0] head_x, head_y, body1_x, body1_y, body2_x, body2_y;
    logic       edge_hit, running, game_over, step_pulse;
    logic [7:0] step_count;
    logic [17:0] act_pos;

    int checks = 0;
    int errors = 0;

    snake_motion_ctrl #(.TICK_DIV(4), .START_X(3), .START_Y(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .dir_valid      (dir_valid),
        .dir_in         (dir_in),
        .self_collision (self_collision),
        .head_x         (head_x),
        .head_y         (head_y),
        .body1_x        (body1_x),
        .body1_y        (body1_y),
        .body2_x        (body2_x),
        .body2_y        (body2_y),
        .edge_hit       (edge_hit),
        .running        (running),
        .game_over      (game_over),
        .step_pulse     (step_pulse),
        .step_count     (step_count)
    );

    always #5 clk = ~clk;

    assign act_pos = {head_x, head_y, body1_x, body1_y, body2_x, body2_y};

    function automatic logic [17:0] pos(input int hx, hy, b1x, b1y, b2x, b2y);
        return {3'(hx), 3'(hy), 3'(b1x), 3'(b1y), 3'(b2x), 3'(b2y)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        checks++;
        if (act_pos !== pos(3,3,2,3,1,3)) begin
            errors++; $display("FAIL reset_pos got %h exp %h", act_pos, pos(3,3,2,3,1,3));
        end
        checks++;
        if ({running, game_over, edge_hit, step_pulse} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {running, game_over, edge_hit, step_pulse});
        end
        checks++;
        if (step_count !== 8'd0) begin
            errors++; $display("FAIL reset_count got %0d exp 0", step_count);
        end
        rst_n = 1'b1;
        cyc();
        cyc();
        checks++;
        if (running !== 1'b0 || act_pos !== pos(3,3,2,3,1,3)) begin
            errors++; $display("FAIL idle_hold got run=%b pos=%h exp run=0 pos=%h", running, act_pos, pos(3,3,2,3,1,3));
        end
    endtask

    task automatic test_start_steps();
        start = 1'b1;
        cyc();
        checks++;
        if (running !== 1'b1 || step_pulse !== 1'b0) begin
            errors++; $display("FAIL start_run got run=%b pulse=%b exp run=1 pulse=0", running, step_pulse);
        end
        for (int c = 1; c <= 12; c++) begin
            if (c == 3) start = 1'b0;
            cyc();
            checks++;
            if (step_pulse !== (c % 4 == 0)) begin
                errors++; $display("FAIL step_pulse c%0d got %b exp %b", c, step_pulse, (c % 4 == 0));
            end
            if (c % 4 == 0) begin
                checks++;
                if ({head_x, head_y} !== {3'(3 + c / 4), 3'd3}) begin
                    errors++; $display("FAIL step_head c%0d got (%0d,%0d) exp (%0d,3)", c, head_x, head_y, 3 + c / 4);
                end
            end
        end
        checks++;
        if (act_pos !== pos(6,3,5,3,4,3) || step_count !== 8'd3) begin
            errors++; $display("FAIL three_steps got pos=%h cnt=%0d exp pos=%h cnt=3", act_pos, step_count, pos(6,3,5,3,4,3));
        end
    endtask

    task automatic test_edge_exit();
        for (int c = 13; c <= 20; c++) begin
            cyc();
            checks++;
            if (step_pulse !== (c == 16)) begin
                errors++; $display("FAIL edge_pulse c%0d got %b exp %b", c, step_pulse, (c == 16));
            end
        end
        checks++;
        if ({running, game_over, edge_hit} !== 3'b011) begin
            errors++; $display("FAIL edge_state got %b exp 011", {running, game_over, edge_hit});
        end
        checks++;
        if (act_pos !== pos(7,3,6,3,5,3) || step_count !== 8'd4) begin
            errors++; $display("FAIL edge_frozen got pos=%h cnt=%0d exp pos=%h cnt=4", act_pos, step_count, pos(7,3,6,3,5,3));
        end
        dir_valid = 1'b1;
        dir_in = 2'b01;
        cyc();
        cyc();
        cyc();
        dir_valid = 1'b0;
        checks++;
        if (act_pos !== pos(7,3,6,3,5,3) || game_over !== 1'b1 || step_pulse !== 1'b0) begin
            errors++; $display("FAIL over_hold got pos=%h over=%b pulse=%b", act_pos, game_over, step_pulse);
        end
    endtask

    task automatic test_restart();
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if ({running, game_over, edge_hit, step_pulse} !== 4'b1000) begin
            errors++; $display("FAIL restart_flags got %b exp 1000", {running, game_over, edge_hit, step_pulse});
        end
        checks++;
        if (act_pos !== pos(3,3,2,3,1,3) || step_count !== 8'd0) begin
            errors++; $display("FAIL restart_pos got pos=%h cnt=%0d exp pos=%h cnt=0", act_pos, step_count, pos(3,3,2,3,1,3));
        end
    endtask

    task automatic test_dir_requests();
        dir_valid = 1'b1;
        dir_in = 2'b10;
        cyc();
        dir_valid = 1'b0;
        cyc(); cyc(); cyc();
        checks++;
        if (act_pos !== pos(4,3,3,3,2,3)) begin
            errors++; $display("FAIL reversal_drop got %h exp %h", act_pos, pos(4,3,3,3,2,3));
        end
        dir_valid = 1'b1;
        dir_in = 2'b01;
        cyc();
        dir_in = 2'b10;
        cyc();
        dir_valid = 1'b0;
        cyc(); cyc();
        checks++;
        if (act_pos !== pos(4,4,4,3,3,3)) begin
            errors++; $display("FAIL down_then_left got %h exp %h", act_pos, pos(4,4,4,3,3,3));
        end
        cyc(); cyc(); cyc();
        dir_valid = 1'b1;
        dir_in = 2'b00;
        cyc();
        dir_valid = 1'b0;
        checks++;
        if (act_pos !== pos(4,5,4,4,4,3)) begin
            errors++; $display("FAIL req_on_step got %h exp %h", act_pos, pos(4,5,4,4,4,3));
        end
        cyc(); cyc(); cyc(); cyc();
        checks++;
        if (act_pos !== pos(5,5,4,5,4,4) || step_count !== 8'd4) begin
            errors++; $display("FAIL req_next_step got pos=%h cnt=%0d exp pos=%h cnt=4", act_pos, step_count, pos(5,5,4,5,4,4));
        end
    endtask

    task automatic test_self_collision();
        cyc();
        self_collision = 1'b1;
        cyc();
        self_collision = 1'b0;
        checks++;
        if ({running, game_over, edge_hit} !== 3'b010 || act_pos !== pos(5,5,4,5,4,4)) begin
            errors++; $display("FAIL coll_mid got flags=%b pos=%h exp flags=010 pos=%h", {running, game_over, edge_hit}, act_pos, pos(5,5,4,5,4,4));
        end
        for (int c = 0; c < 5; c++) cyc();
        checks++;
        if (act_pos !== pos(5,5,4,5,4,4) || step_pulse !== 1'b0 || step_count !== 8'd4) begin
            errors++; $display("FAIL coll_frozen got pos=%h pulse=%b cnt=%0d", act_pos, step_pulse, step_count);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc();
        self_collision = 1'b1;
        cyc();
        self_collision = 1'b0;
        checks++;
        if ({running, game_over, edge_hit, step_pulse} !== 4'b0100) begin
            errors++; $display("FAIL coll_step_flags got %b exp 0100", {running, game_over, edge_hit, step_pulse});
        end
        checks++;
        if (act_pos !== pos(3,3,2,3,1,3) || step_count !== 8'd0) begin
            errors++; $display("FAIL coll_step_noshift got pos=%h cnt=%0d exp pos=%h cnt=0", act_pos, step_count, pos(3,3,2,3,1,3));
        end
    endtask

    task automatic test_reset_mid_step();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        checks++;
        if ({running, game_over, edge_hit, step_pulse} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_flags got %b exp 0000", {running, game_over, edge_hit, step_pulse});
        end
        checks++;
        if (act_pos !== pos(3,3,2,3,1,3) || step_count !== 8'd0) begin
            errors++; $display("FAIL rst_mid_pos got pos=%h cnt=%0d exp pos=%h cnt=0", act_pos, step_count, pos(3,3,2,3,1,3));
        end
        dir_valid = 1'b1;
        dir_in = 2'b01;
        cyc();
        dir_valid = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            checks++;
            if (step_pulse !== (c == 4)) begin
                errors++; $display("FAIL post_rst_pulse c%0d got %b exp %b", c, step_pulse, (c == 4));
            end
        end
        checks++;
        if (act_pos !== pos(3,4,3,3,2,3) || step_count !== 8'd1) begin
            errors++; $display("FAIL idle_dir got pos=%h cnt=%0d exp pos=%h cnt=1", act_pos, step_count, pos(3,4,3,3,2,3));
        end
    endtask

    initial begin
        test_reset();
        test_start_steps();
        test_edge_exit();
        test_restart();
        test_dir_requests();
        test_self_collision();
        test_reset_mid_step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
